sva_fail_logger: RTL and testbench

//   Downstream collector for the assertion-checker FSMs. Takes one fail pulse per checker per

---
 rtl/sva_log_pkg.sv | 42 ++++
 rtl/sva_evt_fifo.sv | 69 ++++++
 rtl/sva_fail_logger.sv | 143 ++++++++++++++
 tb/tb_sva_fail_logger.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sva_log_pkg.sv
// ============================================================================
// Module : sva_log_pkg
// Brief  : Shared types and helpers for the assertion fail logger.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sva_log_pkg;

  localparam int N_CHK = 8;
  localparam int TS_W  = 16;
  localparam int DEPTH = 4;
  localparam int IDX_W = $clog2(N_CHK);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [TS_W-1:0]  ts;
  } evt_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) r = 5'(i);
    end
    return r;
  endfunction

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sva_evt_fifo.sv
// ============================================================================
// Module : sva_evt_fifo
// Brief  : Synchronous event FIFO with flush; head entry drives the output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sva_evt_fifo
  import sva_log_pkg::*;
#(
  parameter int DATA_W = 19,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_full
);

  localparam int c_PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr;
  logic [c_PTR_W-1:0] r_rd;
  logic [c_PTR_W:0]   r_cnt;
  logic               w_empty;
  logic               w_push_ok;
  logic               w_pop_ok;

  assign w_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == (c_PTR_W+1)'(DEPTH));
  assign o_valid   = !w_empty;
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !w_empty;
  // Masked so an empty FIFO presents zeros rather than stale entries.
  assign o_data    = w_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + c_PTR_W'(1);
      end
      if (w_pop_ok) r_rd <= r_rd + c_PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_cnt <= r_cnt + (c_PTR_W+1)'(1);
        2'b01:   r_cnt <= r_cnt - (c_PTR_W+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sva_fail_logger.sv
// ============================================================================
// Module : sva_fail_logger
// Brief  : Collects checker fail pulses into sticky flags, saturating counters,
//          first-fail capture and a timestamped event stream with drop counting.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sva_fail_logger
  import sva_log_pkg::*;
#(
  parameter int N_CHK  = 8,
  parameter int CNT_W  = 8,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8,
  parameter int c_IDX_W = (N_CHK > 1) ? $clog2(N_CHK) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_CHK-1:0]       fail_i,
  input  logic                   clr_i,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [c_IDX_W-1:0]     evt_idx,
  output logic [TS_W-1:0]        evt_ts,
  output logic [N_CHK-1:0]       fail_sticky,
  output logic [N_CHK*CNT_W-1:0] fail_cnt,
  output logic                   first_valid,
  output logic [c_IDX_W-1:0]     first_idx,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_cnt
);

  localparam int               c_EVT_W    = c_IDX_W + TS_W;
  localparam int               c_DSUM_W   = DROP_W + 6;
  localparam logic [DROP_W-1:0] c_DROP_MAX = '1;

  logic [TS_W-1:0]    r_ts;
  logic [N_CHK-1:0]   r_pend;
  logic [TS_W-1:0]    r_pend_ts [N_CHK];
  logic [N_CHK-1:0]   r_sticky;
  logic [CNT_W-1:0]   r_cnt [N_CHK];
  logic               r_first_valid;
  logic [c_IDX_W-1:0] r_first_idx;
  logic               r_overflow;
  logic [DROP_W-1:0]  r_drop;

  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic [c_IDX_W-1:0] w_gidx;
  logic [N_CHK-1:0]   w_gnt;
  logic [N_CHK-1:0]   w_coal;
  logic [N_CHK-1:0]   w_set;
  logic [c_DSUM_W-1:0] w_drop_sum;
  logic [DROP_W-1:0]  w_drop_nxt;
  logic [c_EVT_W-1:0] w_fifo_dout;

  // Grant the lowest pending checker whenever the FIFO has room.
  assign w_push = (|r_pend) && !w_full;
  assign w_gidx = c_IDX_W'(lowest_set(32'(r_pend)));
  assign w_gnt  = w_push ? (N_CHK'(1) << w_gidx) : '0;
  assign w_coal = fail_i & r_pend & ~w_gnt;
  assign w_set  = fail_i & (~r_pend | w_gnt);
  assign w_pop  = evt_valid && evt_ready;

  assign w_drop_sum = c_DSUM_W'(r_drop) + c_DSUM_W'(popcount(32'(w_coal)));
  assign w_drop_nxt = (w_drop_sum > c_DSUM_W'(c_DROP_MAX)) ? c_DROP_MAX
                                                           : w_drop_sum[DROP_W-1:0];

  always_ff @(posedge CLK) begin
    if (RST) r_ts <= '0;
    else     r_ts <= r_ts + TS_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST || clr_i) begin
      r_pend <= '0;
      for (int i = 0; i < N_CHK; i++) r_pend_ts[i] <= '0;
    end else begin
      r_pend <= (r_pend & ~w_gnt) | fail_i;
      for (int i = 0; i < N_CHK; i++) begin
        if (w_set[i]) r_pend_ts[i] <= r_ts;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || clr_i) begin
      r_sticky      <= '0;
      r_first_valid <= 1'b0;
      r_first_idx   <= '0;
      r_overflow    <= 1'b0;
      r_drop        <= '0;
    end else begin
      r_sticky <= r_sticky | fail_i;
      if (!r_first_valid && (|fail_i)) begin
        r_first_valid <= 1'b1;
        r_first_idx   <= c_IDX_W'(lowest_set(32'(fail_i)));
      end
      if (|w_coal) begin
        r_overflow <= 1'b1;
        r_drop     <= w_drop_nxt;
      end
    end
  end

  for (genvar gi = 0; gi < N_CHK; gi++) begin : g_chk
    always_ff @(posedge CLK) begin
      if (RST || clr_i)
        r_cnt[gi] <= '0;
      else if (fail_i[gi] && (r_cnt[gi] != '1))
        r_cnt[gi] <= r_cnt[gi] + CNT_W'(1);
    end
    assign fail_cnt[gi*CNT_W +: CNT_W] = r_cnt[gi];
  end

  sva_evt_fifo #(
    .DATA_W (c_EVT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_flush (clr_i),
    .i_push  (w_push),
    .i_data  ({w_gidx, r_pend_ts[w_gidx]}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_dout),
    .o_valid (evt_valid),
    .o_full  (w_full)
  );

  assign {evt_idx, evt_ts} = w_fifo_dout;
  assign fail_sticky = r_sticky;
  assign first_valid = r_first_valid;
  assign first_idx   = r_first_idx;
  assign overflow    = r_overflow;
  assign drop_cnt    = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_sva_fail_logger.sv
// ============================================================================
// Module : tb_sva_fail_logger
// Brief  : Directed vector table plus multi-cycle sequences for sva_fail_logger.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sva_fail_logger;

  logic        CLK;
  logic        RST;
  logic [7:0]  fail_i;
  logic        clr_i;
  logic        evt_valid;
  logic        evt_ready;
  logic [2:0]  evt_idx;
  logic [15:0] evt_ts;
  logic [7:0]  fail_sticky;
  logic [63:0] fail_cnt;
  logic        first_valid;
  logic [2:0]  first_idx;
  logic        overflow;
  logic [7:0]  drop_cnt;

  sva_fail_logger #(
    .N_CHK(8), .CNT_W(8), .TS_W(16), .DEPTH(4), .DROP_W(8)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .fail_i      (fail_i),
    .clr_i       (clr_i),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_idx     (evt_idx),
    .evt_ts      (evt_ts),
    .fail_sticky (fail_sticky),
    .fail_cnt    (fail_cnt),
    .first_valid (first_valid),
    .first_idx   (first_idx),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Independent cycle-stamp model: value during a cycle equals the DUT stamp.
  logic [15:0] mts;
  always @(posedge CLK) begin
    if (RST) mts <= '0;
    else     mts <= mts + 16'd1;
  end

  typedef struct {
    logic [7:0]  fail;
    logic        clr;
    logic        valid;
    logic [2:0]  idx;
    logic [15:0] ts;
    logic [7:0]  sticky;
    logic [63:0] cnt;
    logic        fv;
    logic [2:0]  fi;
  } vec_t;

  vec_t tbl [14];
  int   n_pass = 0;
  int   n_total = 0;
  logic [2:0]  gi  [16];
  logic [15:0] gts [16];
  int   got;
  logic [15:0] t0;
  logic [15:0] r0;
  int   vcount;

  function automatic vec_t mk(logic [7:0] f, logic c, logic v, logic [2:0] ix,
                              logic [15:0] t, logic [7:0] s, logic [63:0] cn,
                              logic fv, logic [2:0] fi);
    vec_t x;
    x.fail = f; x.clr = c; x.valid = v; x.idx = ix; x.ts = t;
    x.sticky = s; x.cnt = cn; x.fv = fv; x.fi = fi;
    return x;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic collect(input int n, input int maxc);
    got = 0;
    for (int c = 0; c < maxc && got < n; c++) begin
      if (evt_valid) begin
        gi[got]  = evt_idx;
        gts[got] = evt_ts;
        got++;
      end
      tick();
    end
  endtask

  task automatic clear();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
  endtask

  initial begin
    RST = 1'b1; fail_i = '0; clr_i = 1'b0; evt_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_state",
        {evt_valid, evt_idx, evt_ts, fail_sticky, fail_cnt, first_valid, first_idx, overflow, drop_cnt},
        128'd0);
    RST = 1'b0;

    // Row k is driven while the stamp equals k; outputs checked after its edge.
    for (int k = 0; k < 5; k++) tbl[k] = mk(8'h00, 0, 0, 0, 0, 8'h00, 64'h0, 0, 0);
    tbl[5]  = mk(8'h04, 0, 0, 0, 0,  8'h04, 64'h10000, 1, 2);
    tbl[6]  = mk(8'h00, 0, 1, 2, 5,  8'h04, 64'h10000, 1, 2);
    tbl[7]  = mk(8'h00, 0, 0, 0, 0,  8'h04, 64'h10000, 1, 2);
    tbl[8]  = mk(8'h00, 1, 0, 0, 0,  8'h00, 64'h0, 0, 0);
    tbl[9]  = mk(8'h00, 0, 0, 0, 0,  8'h00, 64'h0, 0, 0);
    tbl[10] = mk(8'h81, 0, 0, 0, 0,  8'h81, 64'h0100000000000001, 1, 0);
    tbl[11] = mk(8'h00, 0, 1, 0, 10, 8'h81, 64'h0100000000000001, 1, 0);
    tbl[12] = mk(8'h00, 0, 1, 7, 10, 8'h81, 64'h0100000000000001, 1, 0);
    tbl[13] = mk(8'h00, 0, 0, 0, 0,  8'h81, 64'h0100000000000001, 1, 0);

    for (int k = 0; k < 14; k++) begin
      fail_i = tbl[k].fail;
      clr_i  = tbl[k].clr;
      tick();
      chk($sformatf("row%0d", k),
          {evt_valid, evt_idx, evt_ts, fail_sticky, fail_cnt, first_valid, first_idx, overflow, drop_cnt},
          {tbl[k].valid, tbl[k].idx, tbl[k].ts, tbl[k].sticky, tbl[k].cnt,
           tbl[k].fv, tbl[k].fi, 1'b0, 8'h00});
    end
    fail_i = '0; clr_i = 1'b0;

    // Backpressure: fill the FIFO, then coalesce four pending bits.
    clear();
    evt_ready = 1'b0;
    t0 = mts;
    fail_i = 8'hFF;
    tick();
    fail_i = 8'h00;
    repeat (5) tick();
    chk("bp_head", {evt_valid, evt_idx, evt_ts}, {1'b1, 3'd0, t0});
    chk("bp_cnt1", fail_cnt, 64'h0101010101010101);
    r0 = mts;
    fail_i = 8'hFF;
    tick();
    fail_i = 8'h00;
    chk("bp_drop", {overflow, drop_cnt}, {1'b1, 8'd4});
    chk("bp_cnt2", {fail_sticky, fail_cnt}, {8'hFF, 64'h0202020202020202});
    evt_ready = 1'b1;
    collect(12, 60);
    chk("bp_num", 128'(got), 128'd12);
    for (int e = 0; e < 12; e++) begin
      logic [2:0]  ei;
      logic [15:0] et;
      if (e < 4)      begin ei = 3'(e);     et = t0; end
      else if (e < 8) begin ei = 3'(e - 4); et = r0; end
      else            begin ei = 3'(e - 4); et = t0; end
      chk($sformatf("bp_evt%0d", e), {gi[e], gts[e]}, {ei, et});
    end
    chk("bp_empty", 128'(evt_valid), 128'd0);

    // Counter saturation under a continuous fail.
    clear();
    fail_i = 8'h08;
    repeat (300) tick();
    fail_i = 8'h00;
    chk("sat_cnt3", {fail_cnt[31:24], fail_sticky, drop_cnt}, {8'hFF, 8'h08, 8'h00});
    repeat (4) tick();

    // Clear wins over a same-cycle fail and flushes queued events.
    clear();
    evt_ready = 1'b0;
    fail_i = 8'h03;
    tick();
    fail_i = 8'h00;
    repeat (3) tick();
    chk("clr_pre", 128'(evt_valid), 128'd1);
    clr_i = 1'b1; fail_i = 8'h02;
    tick();
    clr_i = 1'b0; fail_i = 8'h00;
    chk("clr_all",
        {evt_valid, evt_idx, evt_ts, fail_sticky, fail_cnt, first_valid, first_idx, overflow, drop_cnt},
        128'd0);
    evt_ready = 1'b1;
    vcount = 0;
    for (int c = 0; c < 6; c++) begin
      if (evt_valid) vcount++;
      tick();
    end
    chk("clr_noevt", 128'(vcount), 128'd0);

    // Stamp wrap: events stamped FFFF then 0000, in order.
    while (mts != 16'hFFFF) tick();
    fail_i = 8'h01;
    tick();
    fail_i = 8'h01;
    tick();
    fail_i = 8'h00;
    collect(2, 10);
    chk("wrap_num", 128'(got), 128'd2);
    chk("wrap_e0", {gi[0], gts[0]}, {3'd0, 16'hFFFF});
    chk("wrap_e1", {gi[1], gts[1]}, {3'd0, 16'h0000});
    chk("wrap_drop", {overflow, drop_cnt}, 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
